// File: rtl/mat_addsub_seq.sv
// mat_addsub_seq
// Sequential signed matrix add / subtract / pass-through. LANES elements are
// processed per clock in row-major order and written into a registered result
// matrix that is one bit wider than the operands, so results are exact unless
// saturation is enabled.
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   start     request an operation (sampled only while idle)
//   op        0 = A+B, 1 = A-B, 2 = B-A, 3 = A (latched at start)
//   mat_a     signed operand A, held stable until done
//   mat_b     signed operand B, held stable until done
//   mat_out   signed registered result, N_BITS+1 wide per element
//   busy      high whenever the controller is not idle
//   done      one-cycle pulse once mat_out is complete
//   sat_flag  sticky: some element was clipped during the current operation
module mat_addsub_seq #(
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8,
  parameter int N_BITS = 32,
  parameter int LANES  = 4,
  parameter int SAT    = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic signed [N_BITS-1:0] mat_a   [SIZE_A][SIZE_B],
  input  logic signed [N_BITS-1:0] mat_b   [SIZE_A][SIZE_B],
  output logic signed [N_BITS:0]   mat_out [SIZE_A][SIZE_B],
  output logic                     busy,
  output logic                     done,
  output logic                     sat_flag
);

  localparam int NE = SIZE_A * SIZE_B;
  localparam int NB = NE / LANES;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;

  // Clip limits of the N_BITS signed range, sign-extended to N_BITS+1.
  localparam logic signed [N_BITS:0] MAX_V = {2'b00, {(N_BITS-1){1'b1}}};
  localparam logic signed [N_BITS:0] MIN_V = {2'b11, {(N_BITS-1){1'b0}}};

  generate
    if ((NE % LANES) != 0) begin : g_lanes_check
      $error("mat_addsub_seq: LANES must divide SIZE_A*SIZE_B");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [BW-1:0]   beat;
  logic [1:0]      op_lat;

  logic signed [N_BITS-1:0] flat_a [NE];
  logic signed [N_BITS-1:0] flat_b [NE];
  logic [IW-1:0]            lane_idx [LANES];
  logic signed [N_BITS:0]   lane_res [LANES];
  logic [LANES-1:0]         lane_clip;

  // Row-major flattening so each lane can pick its element by flat index.
  for (genvar gi = 0; gi < SIZE_A; gi++) begin : g_row
    for (genvar gj = 0; gj < SIZE_B; gj++) begin : g_col
      assign flat_a[gi*SIZE_B + gj] = mat_a[gi][gj];
      assign flat_b[gi*SIZE_B + gj] = mat_b[gi][gj];
    end
  end

  // One adder per lane, shared across all beats through the operand mux.
  for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
    logic signed [N_BITS:0] a_ext, b_ext, raw, res;
    logic                   clip;

    assign lane_idx[gl] = IW'(beat) * IW'(LANES) + IW'(gl);

    always_comb begin
      a_ext = {flat_a[lane_idx[gl]][N_BITS-1], flat_a[lane_idx[gl]]};
      b_ext = {flat_b[lane_idx[gl]][N_BITS-1], flat_b[lane_idx[gl]]};
      unique case (op_lat)
        2'd0:    raw = a_ext + b_ext;
        2'd1:    raw = a_ext - b_ext;
        2'd2:    raw = b_ext - a_ext;
        default: raw = a_ext;
      endcase
      res  = raw;
      clip = 1'b0;
      // The exact result leaves the N_BITS range exactly when its top two bits differ.
      if ((SAT != 0) && (raw[N_BITS] != raw[N_BITS-1])) begin
        res  = raw[N_BITS] ? MIN_V : MAX_V;
        clip = 1'b1;
      end
    end

    assign lane_res[gl]  = res;
    assign lane_clip[gl] = clip;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (beat == BW'(NB - 1)) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      beat     <= '0;
      op_lat   <= 2'd0;
      sat_flag <= 1'b0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          beat <= '0;
          if (start) begin
            op_lat   <= op;
            sat_flag <= 1'b0;
          end
        end
        RUN: begin
          beat <= beat + BW'(1);
          if ((SAT != 0) && (|lane_clip)) sat_flag <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Element k is owned by lane k%LANES and written on beat k/LANES; all other
  // elements hold, so partially written matrices keep their previous contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SIZE_A; i++)
        for (int j = 0; j < SIZE_B; j++)
          mat_out[i][j] <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < SIZE_A; i++)
        for (int j = 0; j < SIZE_B; j++)
          if (beat == BW'((i*SIZE_B + j) / LANES))
            mat_out[i][j] <= lane_res[(i*SIZE_B + j) % LANES];
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
